sweep_counter_ctrl: RTL and testbench

//   Sequences an embedded 4-bit up/down counter through programmed triangular sweeps: lo -> hi -> lo, repeated n times.

---
 rtl/sweep_ctrl_pkg.sv | 20 ++
 rtl/updown_counter.sv | 36 +++
 rtl/sweep_counter_ctrl.sv | 155 +++++++++++++++
 tb/tb_sweep_counter_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sweep_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sweep_ctrl_pkg                                                  |
// | Brief    : Shared state encoding and default widths for the sweep control. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package sweep_ctrl_pkg;

    localparam int c_width_default = 4;
    localparam int c_cnt_w_default = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/updown_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : updown_counter                                                  |
// | Brief    : Loadable up/down counter; load has priority over enable.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module updown_counter
    import sweep_ctrl_pkg::*;
#(
    parameter int WIDTH = c_width_default
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             mode,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en) begin
            r_count <= mode ? (r_count - 1'b1) : (r_count + 1'b1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/sweep_counter_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sweep_counter_ctrl                                              |
// | Brief    : Runs an up/down counter through n triangular lo->hi->lo sweeps. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sweep_counter_ctrl
    import sweep_ctrl_pkg::*;
#(
    parameter int WIDTH = c_width_default,
    parameter int CNT_W = c_cnt_w_default
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [CNT_W-1:0] n_sweeps,
    output logic [WIDTH-1:0] count,
    output logic             mode,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] sweep_idx
);

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic [CNT_W-1:0] r_n;
    logic [CNT_W-1:0] r_sweep_idx;
    logic             r_err;

    logic [WIDTH-1:0] w_count;
    logic [WIDTH-1:0] w_count_inc;
    logic [WIDTH-1:0] w_count_dec;
    logic [CNT_W-1:0] w_idx_plus;
    logic             w_start_ok;

    logic             w_load;
    logic             w_en;
    logic             w_cnt_mode;
    logic             w_latch;
    logic             w_idx_clr;
    logic             w_idx_inc;
    logic             w_err_nxt;

    // Turn-around decisions look at the value the counter is about to take.
    assign w_count_inc = w_count + 1'b1;
    assign w_count_dec = w_count - 1'b1;
    assign w_idx_plus  = r_sweep_idx + 1'b1;
    assign w_start_ok  = (lo < hi) && (n_sweeps != '0);

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_en        = 1'b0;
        w_cnt_mode  = 1'b0;
        w_latch     = 1'b0;
        w_idx_clr   = 1'b0;
        w_idx_inc   = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !abort) begin
                    if (w_start_ok) begin
                        w_latch     = 1'b1;
                        w_load      = 1'b1;
                        w_idx_clr   = 1'b1;
                        w_state_nxt = UP;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            UP: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_en = 1'b1;
                    if (w_count_inc == r_hi) begin
                        w_state_nxt = DOWN;
                    end
                end
            end
            DOWN: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_en       = 1'b1;
                    w_cnt_mode = 1'b1;
                    if (w_count_dec == r_lo) begin
                        w_idx_inc   = 1'b1;
                        w_state_nxt = (w_idx_plus == r_n) ? DONE : UP;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_lo        <= '0;
            r_hi        <= '0;
            r_n         <= '0;
            r_sweep_idx <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_err_nxt;
            if (w_latch) begin
                r_lo <= lo;
                r_hi <= hi;
                r_n  <= n_sweeps;
            end
            if (w_idx_clr) begin
                r_sweep_idx <= '0;
            end else if (w_idx_inc) begin
                r_sweep_idx <= w_idx_plus;
            end
        end
    end

    // The counter loads from the live lo input on the same edge the copy is latched.
    updown_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (w_load),
        .load_val (lo),
        .en       (w_en),
        .mode     (w_cnt_mode),
        .count    (w_count)
    );

    assign count     = w_count;
    assign mode      = (r_state == DOWN);
    assign busy      = (r_state == UP) || (r_state == DOWN);
    assign done      = (r_state == DONE);
    assign err       = r_err;
    assign sweep_idx = r_sweep_idx;

endmodule
`default_nettype wire

// File: tb/tb_sweep_counter_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sweep_counter_ctrl                                           |
// | Brief    : Directed vector table plus hand sequences for sweep_counter_ctrl|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_sweep_counter_ctrl;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       abort;
    logic [3:0] lo;
    logic [3:0] hi;
    logic [3:0] n_sweeps;
    logic [3:0] count;
    logic       mode;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] sweep_idx;

    int n_checks;
    int n_errors;

    typedef struct {
        logic       s;
        logic       a;
        logic [3:0] l;
        logic [3:0] h;
        logic [3:0] n;
        logic [3:0] e_count;
        logic       e_mode;
        logic       e_busy;
        logic       e_done;
        logic       e_err;
        logic [3:0] e_idx;
    } vec_t;

    localparam int c_num_vecs = 27;
    vec_t vecs [c_num_vecs];

    sweep_counter_ctrl #(
        .WIDTH (4),
        .CNT_W (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .abort     (abort),
        .lo        (lo),
        .hi        (hi),
        .n_sweeps  (n_sweeps),
        .count     (count),
        .mode      (mode),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .sweep_idx (sweep_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic s, input logic a, input logic [3:0] l,
                                input logic [3:0] h, input logic [3:0] n,
                                input logic [3:0] c, input logic m, input logic b,
                                input logic d, input logic e, input logic [3:0] i);
        vec_t v;
        v.s = s; v.a = a; v.l = l; v.h = h; v.n = n;
        v.e_count = c; v.e_mode = m; v.e_busy = b; v.e_done = d; v.e_err = e; v.e_idx = i;
        return v;
    endfunction

    task automatic chk(input string name, input int tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s [%0d]: got %0h, expected %0h", name, tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string name, input int tag, input logic [3:0] c,
                           input logic m, input logic b, input logic d, input logic e,
                           input logic [3:0] i);
        chk({name, ".count"}, tag, 32'(count), 32'(c));
        chk({name, ".mode"}, tag, 32'(mode), 32'(m));
        chk({name, ".busy"}, tag, 32'(busy), 32'(b));
        chk({name, ".done"}, tag, 32'(done), 32'(d));
        chk({name, ".err"}, tag, 32'(err), 32'(e));
        chk({name, ".sweep_idx"}, tag, 32'(sweep_idx), 32'(i));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        lo       = 4'd0;
        hi       = 4'd0;
        n_sweeps = 4'd0;

        //            s  a  lo  hi  n  | cnt m  b  d  e  idx
        vecs[0]  = mk(1, 0, 2,  5,  2,   2,  0, 1, 0, 0, 0);
        vecs[1]  = mk(0, 0, 2,  5,  2,   3,  0, 1, 0, 0, 0);
        vecs[2]  = mk(0, 0, 2,  5,  2,   4,  0, 1, 0, 0, 0);
        vecs[3]  = mk(0, 0, 2,  5,  2,   5,  1, 1, 0, 0, 0);
        vecs[4]  = mk(0, 0, 2,  5,  2,   4,  1, 1, 0, 0, 0);
        vecs[5]  = mk(0, 0, 2,  5,  2,   3,  1, 1, 0, 0, 0);
        vecs[6]  = mk(0, 0, 2,  5,  2,   2,  0, 1, 0, 0, 1);
        vecs[7]  = mk(0, 0, 2,  5,  2,   3,  0, 1, 0, 0, 1);
        vecs[8]  = mk(0, 0, 2,  5,  2,   4,  0, 1, 0, 0, 1);
        vecs[9]  = mk(0, 0, 2,  5,  2,   5,  1, 1, 0, 0, 1);
        vecs[10] = mk(0, 0, 2,  5,  2,   4,  1, 1, 0, 0, 1);
        vecs[11] = mk(0, 0, 2,  5,  2,   3,  1, 1, 0, 0, 1);
        vecs[12] = mk(0, 0, 2,  5,  2,   2,  0, 0, 1, 0, 2);
        vecs[13] = mk(0, 0, 2,  5,  2,   2,  0, 0, 0, 0, 2);
        // rejected starts: lo==hi, then n_sweeps==0, then start+abort together
        vecs[14] = mk(1, 0, 5,  5,  2,   2,  0, 0, 0, 1, 2);
        vecs[15] = mk(0, 0, 5,  5,  2,   2,  0, 0, 0, 0, 2);
        vecs[16] = mk(1, 0, 2,  5,  0,   2,  0, 0, 0, 1, 2);
        vecs[17] = mk(0, 0, 2,  5,  0,   2,  0, 0, 0, 0, 2);
        vecs[18] = mk(1, 1, 2,  5,  1,   2,  0, 0, 0, 0, 2);
        vecs[19] = mk(0, 0, 2,  5,  1,   2,  0, 0, 0, 0, 2);
        // lo=1 hi=3 n=1 run with start pulses and bound changes mid-run
        vecs[20] = mk(1, 0, 1,  3,  1,   1,  0, 1, 0, 0, 0);
        vecs[21] = mk(1, 0, 0,  9,  5,   2,  0, 1, 0, 0, 0);
        vecs[22] = mk(1, 0, 9,  2,  0,   3,  1, 1, 0, 0, 0);
        vecs[23] = mk(0, 0, 0,  1,  3,   2,  1, 1, 0, 0, 0);
        vecs[24] = mk(0, 0, 0,  1,  3,   1,  0, 0, 1, 0, 1);
        vecs[25] = mk(1, 0, 5,  5,  2,   1,  0, 0, 0, 0, 1);
        vecs[26] = mk(0, 0, 5,  5,  2,   1,  0, 0, 0, 0, 1);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        reset_n = 1'b1;

        // Table-driven vectors: inputs set, one edge, outputs compared
        for (int i = 0; i < c_num_vecs; i++) begin
            start    = vecs[i].s;
            abort    = vecs[i].a;
            lo       = vecs[i].l;
            hi       = vecs[i].h;
            n_sweeps = vecs[i].n;
            step();
            chk_all("vec", i, vecs[i].e_count, vecs[i].e_mode, vecs[i].e_busy,
                    vecs[i].e_done, vecs[i].e_err, vecs[i].e_idx);
        end
        start = 1'b0;

        // Abort at count=4 on the first up leg, then restart from lo
        lo = 4'd2; hi = 4'd5; n_sweeps = 4'd2; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk_all("abort_pre", 0, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_all("abort_edge", 0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        step();
        chk_all("abort_hold", 0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk_all("restart", 0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        abort = 1'b1;
        step();
        abort = 1'b0;

        // Full-range sweep: 0 -> 15 -> 0 with no wrap, done on edge 31
        lo = 4'd0; hi = 4'd15; n_sweeps = 4'd1; start = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            step();
            start = 1'b0;
            chk("full.count", k, 32'(count), (k <= 16) ? 32'(k - 1) : 32'(31 - k));
            chk("full.done", k, 32'(done), (k == 31) ? 32'd1 : 32'd0);
        end
        chk("full.mode_top", 0, 32'(mode), 32'd0);
        step();
        chk_all("full_idle", 0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);

        // Asynchronous reset mid-run, mid-cycle
        lo = 4'd3; hi = 4'd7; n_sweeps = 4'd3; start = 1'b1;
        step();
        start = 1'b0;
        repeat (13) step();
        chk_all("prereset", 0, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all("async_reset", 0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        #2;
        reset_n = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
